// File: rtl/gate_vector_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_vector_checker_if
// Brief    : Stimulus/response bundle between a gate vector checker and the
//            environment that owns the gate under test.
// Revision : 1.0
// ============================================================================
interface gate_vector_checker_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 3
);
    logic                 start;
    logic [2**N_IN-1:0]   expected;
    logic                 dut_y;
    logic [N_IN-1:0]      vec_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     err_count;
    logic [N_IN-1:0]      first_err_vec;
    logic                 first_err_valid;

    // master: the environment (starts runs, supplies truth table and dut_y)
    modport master (
        output start, expected, dut_y,
        input  vec_out, busy, done, pass, err_count, first_err_vec, first_err_valid
    );

    // slave: the checker itself
    modport slave (
        input  start, expected, dut_y,
        output vec_out, busy, done, pass, err_count, first_err_vec, first_err_valid
    );
endinterface
`default_nettype wire

// File: rtl/gate_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_vector_checker
// Brief    : Walks every input vector of a small combinational block, samples
//            its output after a settle delay and scores it against a table.
// Revision : 1.0
// ============================================================================
module gate_vector_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 3
) (
    input  wire logic            clk,
    input  wire logic            rst,
    gate_vector_checker_if.slave bus
);

    localparam int                c_CNT_W      = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int                c_TBL_W      = 2**N_IN;
    localparam logic [c_CNT_W-1:0] c_SETTLE_CNT = c_CNT_W'(SETTLE);
    localparam logic [ERR_W-1:0]  c_ERR_MAX    = '1;
    localparam logic [N_IN-1:0]   c_VEC_LAST   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_TBL_W-1:0]   r_table;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [N_IN-1:0]      r_vec;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [ERR_W-1:0]     r_err_count;
    logic [N_IN-1:0]      r_first_err_vec;
    logic                 r_first_err_valid;

    logic                 w_mismatch;

    // Only consulted on sample edges, so settle-time glitches on dut_y are inert.
    assign w_mismatch = bus.dut_y ^ r_table[r_vec];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_table           <= '0;
            r_cnt             <= '0;
            r_vec             <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_table           <= bus.expected;
                        r_vec             <= '0;
                        r_cnt             <= c_SETTLE_CNT;
                        r_err_count       <= '0;
                        r_first_err_vec   <= '0;
                        r_first_err_valid <= 1'b0;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                        r_busy            <= 1'b1;
                        r_state           <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else begin
                        if (w_mismatch) begin
                            if (r_err_count != c_ERR_MAX) begin
                                r_err_count <= r_err_count + ERR_W'(1);
                            end
                            if (!r_first_err_valid) begin
                                r_first_err_vec   <= r_vec;
                                r_first_err_valid <= 1'b1;
                            end
                        end

                        if (r_vec == c_VEC_LAST) begin
                            // A zero count before this sample plus a clean final
                            // sample means the whole run was clean, even if the
                            // counter would otherwise saturate.
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_count == '0) && !w_mismatch;
                        end else begin
                            r_vec <= r_vec + N_IN'(1);
                            r_cnt <= c_SETTLE_CNT;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec_out         = r_vec;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_count       = r_err_count;
    assign bus.first_err_vec   = r_first_err_vec;
    assign bus.first_err_valid = r_first_err_valid;

endmodule
`default_nettype wire

// File: tb/tb_gate_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_vector_checker
// Brief    : Directed bench; one checker at defaults, one with SETTLE=0/ERR_W=1.
// Revision : 1.0
// ============================================================================
module tb_gate_vector_checker;

    localparam int M_OR = 0, M_AND = 1, M_STUCK1 = 2, M_INV_OR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_vector_checker_if #(.N_IN(2), .ERR_W(3)) bus0 ();
    gate_vector_checker_if #(.N_IN(2), .ERR_W(1)) bus1 ();

    gate_vector_checker #(.N_IN(2), .SETTLE(1), .ERR_W(3)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    gate_vector_checker #(.N_IN(2), .SETTLE(0), .ERR_W(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int mode0 = M_OR;
    int mode1 = M_OR;
    int tests = 0;
    int fails = 0;

    // Behavioural gate under test: a = vec[1], b = vec[0].
    function automatic logic gate_fn(input int mode, input logic [1:0] v);
        case (mode)
            M_OR:     return v[1] | v[0];
            M_AND:    return v[1] & v[0];
            M_STUCK1: return 1'b1;
            default:  return ~(v[1] | v[0]);
        endcase
    endfunction

    always_comb bus0.dut_y = gate_fn(mode0, bus0.vec_out);
    always_comb bus1.dut_y = gate_fn(mode1, bus1.vec_out);

    typedef struct {
        int    which;
        int    err;
        int    fvec;
        int    fvalid;
        int    pass;
        string tag;
    } result_t;

    result_t sb[$];

    function automatic result_t model(input int which, input int mode,
                                      input logic [3:0] tbl, input string tag);
        result_t r;
        int errmax = (which == 0) ? 7 : 1;
        int nmis = 0;
        r.which = which; r.err = 0; r.fvec = 0; r.fvalid = 0; r.tag = tag;
        for (int v = 0; v < 4; v++) begin
            if (gate_fn(mode, 2'(v)) != tbl[v]) begin
                nmis++;
                if (r.err < errmax) r.err++;
                if (r.fvalid == 0) begin r.fvalid = 1; r.fvec = v; end
            end
        end
        r.pass = (nmis == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input int which);
        if (which == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
        step();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    function automatic logic done_of(input int which);
        return (which == 0) ? bus0.done : bus1.done;
    endfunction

    task automatic launch(input int which, input int mode, input logic [3:0] tbl,
                          input string tag);
        if (which == 0) begin mode0 = mode; bus0.expected = tbl; end
        else            begin mode1 = mode; bus1.expected = tbl; end
        sb.push_back(model(which, mode, tbl, tag));
        start_pulse(which);
    endtask

    task automatic finish_check(input int which, input int start_cnt, input int exp_cycles);
        int      cycles;
        result_t r;
        cycles = start_cnt;
        while (cycles < 64 && !done_of(which)) begin
            step();
            cycles++;
        end
        check("done_reached", 32'(done_of(which)), 32'd1);
        check("latency", 32'(cycles), 32'(exp_cycles));
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            r = sb.pop_front();
            check("sb_which", 32'(which), 32'(r.which));
            if (which == 0) begin
                check({r.tag, "_err"},    32'(bus0.err_count),       32'(r.err));
                check({r.tag, "_fvalid"}, 32'(bus0.first_err_valid), 32'(r.fvalid));
                check({r.tag, "_fvec"},   32'(bus0.first_err_vec),   32'(r.fvec));
                check({r.tag, "_pass"},   32'(bus0.pass),            32'(r.pass));
                check({r.tag, "_busy"},   32'(bus0.busy),            32'd0);
                check({r.tag, "_vec"},    32'(bus0.vec_out),         32'd3);
            end else begin
                check({r.tag, "_err"},    32'(bus1.err_count),       32'(r.err));
                check({r.tag, "_fvalid"}, 32'(bus1.first_err_valid), 32'(r.fvalid));
                check({r.tag, "_fvec"},   32'(bus1.first_err_vec),   32'(r.fvec));
                check({r.tag, "_pass"},   32'(bus1.pass),            32'(r.pass));
                check({r.tag, "_busy"},   32'(bus1.busy),            32'd0);
            end
        end
    endtask

    task automatic check_idle0(input string tag);
        check({tag, "_vec"},    32'(bus0.vec_out),         32'd0);
        check({tag, "_busy"},   32'(bus0.busy),            32'd0);
        check({tag, "_done"},   32'(bus0.done),            32'd0);
        check({tag, "_pass"},   32'(bus0.pass),            32'd0);
        check({tag, "_err"},    32'(bus0.err_count),       32'd0);
        check({tag, "_fvec"},   32'(bus0.first_err_vec),   32'd0);
        check({tag, "_fvalid"}, 32'(bus0.first_err_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus0.start = 1'b0; bus0.expected = 4'b0000;
        bus1.start = 1'b0; bus1.expected = 4'b0000;
        rst = 1'b1;
        step();
        step();
        check_idle0("reset");
        rst = 1'b0;
        step();

        // Correct OR gate: watch vec_out stepping every two cycles.
        mode0 = M_OR;
        bus0.expected = 4'b1110;
        sb.push_back(model(0, M_OR, 4'b1110, "or_ok"));
        start_pulse(0);
        check("or_busy_e0", 32'(bus0.busy), 32'd1);
        check("or_vec_e0",  32'(bus0.vec_out), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("or_vec_e%0d", k),  32'(bus0.vec_out), 32'((k / 2 > 3) ? 3 : k / 2));
            check($sformatf("or_busy_e%0d", k), 32'(bus0.busy), 32'd1);
            check($sformatf("or_done_e%0d", k), 32'(bus0.done), 32'd0);
        end
        finish_check(0, 7, 8);

        // AND gate against the OR table: vectors 1 and 2 disagree.
        launch(0, M_AND, 4'b1110, "and");
        finish_check(0, 0, 8);

        // Stuck-at-1 output: only vector 0 disagrees.
        launch(0, M_STUCK1, 4'b1110, "stuck1");
        finish_check(0, 0, 8);

        // Reset mid-run once vec_out reaches 2.
        mode0 = M_OR;
        bus0.expected = 4'b1110;
        start_pulse(0);
        n = 0;
        while (bus0.vec_out != 2'd2 && n < 16) begin
            step();
            n++;
        end
        check("midrst_reached_vec2", 32'(bus0.vec_out), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle0("midrst");
        step();
        step();
        check("midrst_stays_idle", 32'(bus0.busy), 32'd0);
        launch(0, M_OR, 4'b1110, "after_rst");
        finish_check(0, 0, 8);

        // Restart from DONE with start re-pulsed and table changed mid-run.
        launch(0, M_OR, 4'b1110, "ignore_mid");
        check("restart_done_drop", 32'(bus0.done), 32'd0);
        check("restart_busy",      32'(bus0.busy), 32'd1);
        check("restart_vec0",      32'(bus0.vec_out), 32'd0);
        step();
        step();
        bus0.expected = 4'b0000;
        start_pulse(0);
        check("mid_start_vec", 32'(bus0.vec_out), 32'd1);
        finish_check(0, 3, 8);

        // SETTLE=0 / ERR_W=1: inverted OR saturates the 1-bit counter.
        launch(1, M_INV_OR, 4'b1110, "sat");
        finish_check(1, 0, 4);
        launch(1, M_OR, 4'b1110, "s0_ok");
        finish_check(1, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Self-checking stimulus and response stage for small combinational gate blocks, such as the 2:1-MUX-built OR gate.
- Sits directly upstream and downstream of the DUT: drives an exhaustive input vector sequence, waits a programmable settle time, samples the DUT output and compares it against a supplied truth table.
- Reports mismatch count, first failing vector and an overall pass/done status, replacing hand-written delay-based stimulus.

Parameters:
- N_IN, 2, number of DUT inputs; sequence covers 2^N_IN vectors.
- SETTLE, 1, cycles between applying a vector and sampling dut_y (0 allowed).
- ERR_W, 3, width of err_count; saturates at 2^ERR_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; honoured only in IDLE or DONE.
- expected  input  2^N_IN  truth table; bit i = expected dut_y for vector i; latched on accepted start.
- dut_y  input  1  DUT output under test.
- vec_out  output  N_IN  registered vector to DUT; MSB = a, LSB = b for N_IN=2.
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE until next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff zero mismatches.
- err_count  output  ERR_W  saturating mismatch count.
- first_err_vec  output  N_IN  index of first mismatching vector.
- first_err_valid  output  1  first_err_vec holds a captured value.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-run): state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_valid=0, settle counter=0, latched table=0.
- States are IDLE, RUN and DONE.
- IDLE/DONE with start=1:
  - latch expected, vec_out<=0, cnt<=SETTLE.
  - clear err_count, first_err_*, done and pass; busy<=1; go to RUN.
- RUN with cnt!=0: cnt<=cnt-1; vec_out held.
- RUN with cnt==0 (sample edge):
  - mismatch = dut_y XOR latched[vec_out].
  - On mismatch: err_count increments unless it is at its maximum. If first_err_valid=0, set first_err_vec<=vec_out and first_err_valid<=1.
  - If vec_out is all-ones: go to DONE, busy<=0, done<=1, pass<=(no mismatch this run, including this sample). vec_out is held at the last vector.
  - Otherwise: vec_out<=vec_out+1, cnt<=SETTLE.
- Each vector occupies SETTLE+1 cycles. With start sampled at edge E0, done is visible after edge E0 + 2^N_IN*(SETTLE+1).
  - Defaults: done after E8; busy high after E0 through E8.
- start while in RUN is ignored; the run continues unaffected.
- start in DONE restarts immediately, with no pass through IDLE.
- Changes on expected after start are ignored until the next accepted start.
- dut_y is sampled only on sample edges; glitches during settle cycles have no effect.
- Saturation: err_count sticks at 2^ERR_W-1; pass still 0.
- SETTLE=0: vector is sampled on the edge after it is applied; one cycle per vector.
- No combinational path from inputs to outputs.

Test Plan:
- Correct OR DUT, expected=4'b1110, pulse start → vec_out steps 0,1,2,3 every 2 cycles; done=1 after 8 cycles; pass=1, err_count=0, first_err_valid=0.
- AND DUT with expected=4'b1110 → mismatches at vectors 1 and 2; err_count=2, first_err_vec=1, first_err_valid=1, pass=0.
- Stuck-at-1 DUT (dut_y=1), expected=4'b1110 → err_count=1, first_err_vec=0, pass=0.
- Reset asserted mid-run (vec_out=2) → next cycle all outputs 0 and state IDLE; a later start runs a full clean sequence with pass=1.
- start re-pulsed during RUN and expected changed mid-run → ignored; results match the original table. Then start in DONE → done drops next cycle and a new run begins at vec_out=0.
- ERR_W=1 with inverted-OR DUT (4 mismatches) → err_count saturates at 1, first_err_vec=0, pass=0. SETTLE=0 run completes in 4 cycles.
